// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encodings and size helper for the LSU request controller
package lsu_pkg;

    localparam int XLEN = 64;

    // Access size encodings as presented by the EXU
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Controller states
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_ACCESS = 2'd1;
    localparam lsu_state_t ST_RESP   = 2'd2;

    // The LSU expects a byte count and builds its mask as ~(8'hFF << LsuType)
    function automatic logic [3:0] size_to_lsutype(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - sign/zero extension of LSB-aligned load data by access size
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = lsu_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            zext,
    output logic [XLEN-1:0] ext_data
);

    // Replicate the top bit of the accessed field unless zero extension is requested
    always_comb begin
        ext_data = rdata;
        case (size)
            SZ_B:    ext_data = {{(XLEN-8){~zext & rdata[7]}}, rdata[7:0]};
            SZ_H:    ext_data = {{(XLEN-16){~zext & rdata[15]}}, rdata[15:0]};
            SZ_W:    ext_data = {{(XLEN-32){~zext & rdata[31]}}, rdata[31:0]};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_req_ctrl.sv
// rtl/lsu_req_ctrl.sv - EXU-to-LSU request controller with fixed access latency; optional LSU_MISALIGN_TRAP_EN
module lsu_req_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN        = lsu_pkg::XLEN,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [4:0]      req_rd,
    output logic            mem_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_lsu_type,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_err
);

    lsu_state_t      state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            wen_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] ext_data;
    logic            accept;
    logic            last_access;
    logic            misalign;

    // Outputs are gated by reset so a reset cycle never shows a live access or response
    assign req_ready    = reset && (state == ST_IDLE);
    assign accept       = req_valid && req_ready;
    assign mem_en       = reset && (state == ST_ACCESS);
    assign last_access  = mem_en && (cnt == 4'd0);
    assign mem_addr     = mem_en ? addr_q : '0;
    assign mem_wdata    = mem_en ? wdata_q : '0;
    assign mem_lsu_type = mem_en ? size_to_lsutype(size_q) : 4'd0;
    assign mem_wen      = last_access && wen_q;
    assign resp_valid   = reset && (state == ST_RESP);

    lsu_load_ext #(.XLEN(XLEN)) u_ext (
        .rdata    (mem_rdata),
        .size     (size_q),
        .zext     (uns_q),
        .ext_data (ext_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    // Low address bits covered by the access size must be zero
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            SZ_H:    misalign = req_addr[0];
            SZ_W:    misalign = |req_addr[1:0];
            SZ_D:    misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // Error flag set for a trapped request, cleared when a real access completes
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_err <= 1'b0;
        end else if (accept && misalign) begin
            resp_err <= 1'b1;
        end else if (last_access) begin
            resp_err <= 1'b0;
        end
    end
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Request FSM: latch on accept, count down the access window, hold the response until taken
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            rd_q      <= 5'd0;
            resp_data <= '0;
            resp_rd   <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wen_q   <= req_wen;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        rd_q    <= req_rd;
                        cnt     <= 4'(MEM_LATENCY - 1);
                        if (misalign) begin
                            state     <= ST_RESP;
                            resp_data <= '0;
                            resp_rd   <= req_rd;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_RESP;
                        resp_data <= wen_q ? '0 : ext_data;
                        resp_rd   <= rd_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb/tb_lsu_req_ctrl.sv - scoreboard bench for lsu_req_ctrl with randomized requests and directed corner cases
module tb_lsu_req_ctrl;

    localparam int LAT = 3;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        wen;
        logic        uns;
        logic        err;
        int          t_resp;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // main DUT (MEM_LATENCY = 3)
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_en, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_lsu_type;
    logic        resp_valid, resp_ready = 1'b1, resp_err;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;

    // second DUT (MEM_LATENCY = 1)
    logic        b_req_valid = 1'b0, b_req_ready, b_req_wen = 1'b0, b_req_unsigned = 1'b0;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0;
    logic [1:0]  b_req_size = '0;
    logic [4:0]  b_req_rd = '0;
    logic        b_mem_en, b_mem_wen;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata = '0;
    logic [3:0]  b_mem_lsu_type;
    logic        b_resp_valid, b_resp_ready = 1'b1, b_resp_err;
    logic [63:0] b_resp_data;
    logic [4:0]  b_resp_rd;

    lsu_req_ctrl #(.XLEN(64), .MEM_LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_lsu_type(mem_lsu_type),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    lsu_req_ctrl #(.XLEN(64), .MEM_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_wen(b_req_wen), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned), .req_rd(b_req_rd),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_lsu_type(b_mem_lsu_type),
        .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .resp_rd(b_resp_rd), .resp_err(b_resp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: keep the low 8*nb bits, fill above with the field's top bit unless unsigned
    function automatic logic [63:0] model_load(input logic [63:0] rd, input int nb, input logic uns);
        logic [63:0] mask, v;
        if (nb == 8) return rd;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = rd & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic model_err(input logic [63:0] addr, input int nb);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % 64'(nb)) != 64'd0;
`else
        return (addr === 64'hx) && (nb < 0);
`endif
    endfunction

    txn_t mq[$];
    txn_t rq[$];
    logic mon_en = 1'b0;
    logic bp_en  = 1'b0;

    // WBU side: random stalls of up to several cycles
    initial begin
        int stall = 0;
        forever begin
            @(posedge clock);
            #1;
            if (!bp_en) begin
                resp_ready = 1'b1;
                stall = 0;
            end else if (stall > 0) begin
                resp_ready = 1'b0;
                stall--;
            end else if ($urandom % 4 == 0) begin
                resp_ready = 1'b0;
                stall = $urandom_range(1, 5);
            end else begin
                resp_ready = 1'b1;
            end
        end
    end

    // LSU-side monitor: checks each access window and supplies read data only in its last cycle
    initial begin
        int acc = 0;
        txn_t f;
        forever begin
            @(negedge clock);
            if (mon_en && mem_en) begin
                if (mq.size() == 0) begin
                    chk("mem_unexpected", {63'd0, mem_en}, 64'd0);
                    mem_rdata = {$urandom, $urandom};
                end else begin
                    f = mq[0];
                    chk("mem_addr", mem_addr, f.addr);
                    chk("mem_lsu_type", {60'd0, mem_lsu_type}, 64'd1 << f.size);
                    chk("mem_wdata", mem_wdata, f.wdata);
                    chk("mem_wen", {63'd0, mem_wen}, {63'd0, f.wen && (acc == LAT - 1)});
                    chk("mem_req_ready", {63'd0, req_ready}, 64'd0);
                    mem_rdata = (acc == LAT - 1) ? f.rdata : {$urandom, $urandom};
                    acc++;
                    if (acc == LAT) begin
                        void'(mq.pop_front());
                        acc = 0;
                    end
                end
            end else begin
                mem_rdata = {$urandom, $urandom};
                if (mon_en) begin
                    chk("idle_mem_wen", {63'd0, mem_wen}, 64'd0);
                    chk("idle_mem_addr", mem_addr, 64'd0);
                end
            end
        end
    end

    // WBU-side monitor: latency on first presentation, stability while stalled, pop on handshake
    initial begin
        logic held = 1'b0;
        txn_t f;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (resp_valid) begin
                    if (rq.size() == 0) begin
                        chk("resp_unexpected", {63'd0, resp_valid}, 64'd0);
                    end else begin
                        f = rq[0];
                        if (!held) chk("resp_latency", 64'(cyc), 64'(f.t_resp));
                        chk("resp_data", resp_data, f.data);
                        chk("resp_rd", {59'd0, resp_rd}, {59'd0, f.rd});
                        chk("resp_err", {63'd0, resp_err}, {63'd0, f.err});
                        chk("resp_req_ready", {63'd0, req_ready}, 64'd0);
                        if (resp_ready) begin
                            void'(rq.pop_front());
                            held = 1'b0;
                        end else begin
                            held = 1'b1;
                        end
                    end
                end else begin
                    if (held) chk("resp_hold", {63'd0, resp_valid}, 64'd1);
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic make_txn(output txn_t t);
        int nb;
        t.size  = 2'($urandom % 4);
        nb      = 1 << t.size;
        t.addr  = {$urandom, $urandom};
        if ($urandom % 2 == 1) t.addr = t.addr & ~64'(nb - 1);
        t.wen   = 1'($urandom % 2);
        t.uns   = 1'($urandom % 2);
        t.rd    = 5'($urandom % 32);
        t.wdata = {$urandom, $urandom};
        t.rdata = {$urandom, $urandom};
        t.err   = model_err(t.addr, nb);
        t.data  = (t.err || t.wen) ? 64'd0 : model_load(t.rdata, nb, t.uns);
        t.t_resp = 0;
    endtask

    task automatic issue(input txn_t t);
        int w = 0;
        req_addr = t.addr; req_wen = t.wen; req_wdata = t.wdata;
        req_size = t.size; req_unsigned = t.uns; req_rd = t.rd;
        req_valid = 1'b1;
        @(negedge clock);
        while (!req_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        chk("req_accept", {63'd0, req_ready}, 64'd1);
        t.t_resp = cyc + 1 + (t.err ? 0 : LAT);
        rq.push_back(t);
        if (!t.err) mq.push_back(t);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr = {$urandom, $urandom};
        req_rd = 5'($urandom % 32);
    endtask

    task automatic run1(input string name, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic wen, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [4:0] rd, input logic [63:0] exp_data);
        int nb = 1 << size;
        logic e = model_err(addr, nb);
        b_req_addr = addr; b_req_size = size; b_req_unsigned = uns; b_req_wen = wen;
        b_req_wdata = wdata; b_req_rd = rd; b_mem_rdata = rdata;
        @(posedge clock); #1;
        b_req_valid = 1'b1;
        @(negedge clock);
        chk({name, "_req_ready"}, {63'd0, b_req_ready}, 64'd1);
        @(posedge clock); #1;
        b_req_valid = 1'b0;
        @(negedge clock);
        if (e) begin
            chk({name, "_mem_en"}, {63'd0, b_mem_en}, 64'd0);
            chk({name, "_resp_valid"}, {63'd0, b_resp_valid}, 64'd1);
            chk({name, "_resp_err"}, {63'd0, b_resp_err}, 64'd1);
            chk({name, "_resp_data"}, b_resp_data, 64'd0);
        end else begin
            chk({name, "_mem_en"}, {63'd0, b_mem_en}, 64'd1);
            chk({name, "_mem_addr"}, b_mem_addr, addr);
            chk({name, "_lsu_type"}, {60'd0, b_mem_lsu_type}, 64'(nb));
            chk({name, "_mem_wen"}, {63'd0, b_mem_wen}, {63'd0, wen});
            chk({name, "_resp_early"}, {63'd0, b_resp_valid}, 64'd0);
            @(negedge clock);
            chk({name, "_resp_valid"}, {63'd0, b_resp_valid}, 64'd1);
            chk({name, "_resp_data"}, b_resp_data, exp_data);
            chk({name, "_resp_err"}, {63'd0, b_resp_err}, 64'd0);
            chk({name, "_mem_off"}, {63'd0, b_mem_en}, 64'd0);
        end
        chk({name, "_resp_rd"}, {59'd0, b_resp_rd}, {59'd0, rd});
        @(negedge clock);
        chk({name, "_back_idle"}, {63'd0, b_req_ready}, 64'd1);
        chk({name, "_resp_done"}, {63'd0, b_resp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int w;

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_lsu_type", {60'd0, mem_lsu_type}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_rd", {59'd0, resp_rd}, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("post_rst_b_req_ready", {63'd0, b_req_ready}, 64'd1);

        // randomized traffic with WBU backpressure
        mon_en = 1'b1;
        bp_en  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            make_txn(t);
            repeat ($urandom % 3) @(posedge clock);
            #1;
            issue(t);
        end
        w = 0;
        while ((rq.size() != 0 || mq.size() != 0) && w < 400) begin
            @(negedge clock);
            w++;
        end
        chk("drain_resp", 64'(rq.size()), 64'd0);
        chk("drain_mem", 64'(mq.size()), 64'd0);
        bp_en = 1'b0;
        @(negedge clock);
        mon_en = 1'b0;

        // reset in the second of three access cycles of a store
        req_addr = 64'h0000_0000_8000_0010; req_wen = 1'b1; req_size = 2'd3;
        req_wdata = 64'h1122_3344_5566_7788; req_rd = 5'd9; req_unsigned = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1;
        @(negedge clock);
        chk("rst_test_accept", {63'd0, req_ready}, 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        chk("rst_test_acc1_en", {63'd0, mem_en}, 64'd1);
        chk("rst_test_acc1_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst_test_acc1_type", {60'd0, mem_lsu_type}, 64'd8);
        @(negedge clock);
        chk("rst_test_acc2_en", {63'd0, mem_en}, 64'd1);
        chk("rst_test_acc2_wen", {63'd0, mem_wen}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_test_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_test_mem_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst_test_mem_addr", mem_addr, 64'd0);
        chk("rst_test_mem_wdata", mem_wdata, 64'd0);
        chk("rst_test_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_test_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_test_resp_data", resp_data, 64'd0);
        chk("rst_test_resp_rd", {59'd0, resp_rd}, 64'd0);
        chk("rst_test_resp_err", {63'd0, resp_err}, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_test_idle_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_test_idle_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst_test_idle_en", {63'd0, mem_en}, 64'd0);
        @(negedge clock);
        chk("rst_test_no_resp", {63'd0, resp_valid}, 64'd0);
        chk("rst_test_no_wen", {63'd0, mem_wen}, 64'd0);

        // single-cycle latency: directed cases
        run1("lb_signed", 64'h0000_0000_8000_0003, 2'd0, 1'b0, 1'b0, 64'd0,
             64'h1234_5678_0000_0080, 5'd3, 64'hFFFF_FFFF_FFFF_FF80);
        run1("lhu", 64'h0000_0000_8000_0004, 2'd1, 1'b1, 1'b0, 64'd0,
             64'h0000_0000_0000_8001, 5'd4, 64'h0000_0000_0000_8001);
        run1("sd", 64'h0000_0000_8000_0008, 2'd3, 1'b0, 1'b1, 64'h1122_3344_5566_7788,
             64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 64'd0);
        run1("lw_misal", 64'h0000_0000_8000_0002, 2'd2, 1'b0, 1'b0, 64'd0,
             64'hFFFF_FFFF_1234_5678, 5'd6, 64'h0000_0000_1234_5678);
        run1("lw_neg", 64'h0000_0000_8000_0010, 2'd2, 1'b0, 1'b0, 64'd0,
             64'h0000_0000_8765_4321, 5'd7, 64'hFFFF_FFFF_8765_4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
